// File: rtl/fifo_read_ctrl_if.sv
// fifo_read_ctrl_if: FIFO read side and downstream valid/ready bundle for
// fifo_read_ctrl. master = the drain controller, slave = FIFO + consumer.
`timescale 1ns/1ps
interface fifo_read_ctrl_if #(
  parameter int DATA_BITS = 10,
  parameter int CNT_BITS  = 16
);
  logic [DATA_BITS-1:0] fifo_data_out;
  logic                 fifo_empty_out;
  logic                 error_fifo_out;
  logic                 fifo_read;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err_clear;
  logic                 error_out;
  logic [1:0]           state;
  logic [CNT_BITS-1:0]  word_count;

  modport master (
    input  fifo_data_out, fifo_empty_out, error_fifo_out, out_ready, err_clear,
    output fifo_read, out_data, out_valid, error_out, state, word_count
  );

  modport slave (
    output fifo_data_out, fifo_empty_out, error_fifo_out, out_ready, err_clear,
    input  fifo_read, out_data, out_valid, error_out, state, word_count
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: drains a synchronous FIFO (1-cycle read latency) into a
// 3-entry skid buffer and presents words over valid/ready at one word/cycle.
// Optional macro FIFO_READ_CTRL_COUNT_EN enables the delivered-word counter;
// without it word_count is tied to zero.
`timescale 1ns/1ps
module fifo_read_ctrl #(
  parameter int DATA_BITS = 10,
  parameter int CNT_BITS  = 16
) (
  input logic              clk,
  input logic              reset,
  fifo_read_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2,
    ERR  = 2'd3
  } state_t;

  logic [DATA_BITS-1:0] mem [3];
  logic [1:0]           wr_ptr, rd_ptr, occ, occ_nxt;
  logic                 pending, rd_en, pop, err_q, err_nxt;
  state_t               st, st_nxt;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are gated only by registered state and the empty flag, so no path
  // from out_ready reaches fifo_read. occ + pending < 3 reserves a slot for
  // every word in flight.
  assign rd_en   = reset && !bus.fifo_empty_out && !err_q &&
                   ((3'(occ) + 3'(pending)) < 3'd3);
  assign pop     = (occ != 2'd0) && bus.out_ready;
  assign occ_nxt = occ + 2'(pending) - 2'(pop);
  // A new error wins over a simultaneous clear.
  assign err_nxt = bus.error_fifo_out | (err_q & ~bus.err_clear);

  assign bus.fifo_read = rd_en;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.error_out = err_q;
  assign bus.state     = st;

  // Next FSM state from next-cycle occupancy, pending and error values.
  always_comb begin
    st_nxt = RUN;
    if (err_nxt)                         st_nxt = ERR;
    else if (occ_nxt == 2'd3)            st_nxt = FULL;
    else if (occ_nxt == 2'd0 && !rd_en)  st_nxt = IDLE;
  end

  // Skid buffer: capture the word read last cycle, advance head on a pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ     <= 2'd0;
      pending <= 1'b0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      pending <= rd_en;
      occ     <= occ_nxt;
      if (pending) begin
        mem[wr_ptr] <= bus.fifo_data_out;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (pop) rd_ptr <= wrap_inc(rd_ptr);
    end
  end

  // FSM and sticky error, both registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      err_q <= 1'b0;
    end else begin
      st    <= st_nxt;
      err_q <= err_nxt;
    end
  end

`ifdef FIFO_READ_CTRL_COUNT_EN
  logic [CNT_BITS-1:0] cnt;

  // Delivered-word counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (pop) cnt <= cnt + CNT_BITS'(1);
  end

  assign bus.word_count = cnt;
`else
  assign bus.word_count = '0;
`endif
endmodule
